// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into press/release/click/double-click/long-press pulses.
// Optional auto-repeat during a long hold is enabled by defining BTN_DECODER_REPEAT_EN.
module button_event_decoder #(
    parameter int unsigned LONG_PRESS_CLK_CNT       = 1000000,
    parameter int unsigned DOUBLE_CLICK_GAP_CLK_CNT = 250000,
    parameter int unsigned REPEAT_CLK_CNT           = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic double_click_pulse,
    output logic long_press_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int unsigned BASE_MAX = (LONG_PRESS_CLK_CNT > DOUBLE_CLICK_GAP_CLK_CNT) ?
                                       LONG_PRESS_CLK_CNT : DOUBLE_CLICK_GAP_CLK_CNT;
`ifdef BTN_DECODER_REPEAT_EN
    localparam int unsigned MAX_CNT = (BASE_MAX > REPEAT_CLK_CNT) ? BASE_MAX : REPEAT_CLK_CNT;
`else
    localparam int unsigned MAX_CNT = BASE_MAX;
`endif
    localparam int unsigned CNT_W = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CLK_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_CLICK_GAP_CLK_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        WAIT_SECOND,
        SECOND_PRESSED,
        LONG_HELD
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             press_next, release_next, click_next, double_next, long_next, repeat_next;
    logic             held_next;

    // Saturating increment: the counter must never wrap back into range.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_ONE;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        click_next   = 1'b0;
        double_next  = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (btn_level) begin
                    press_next = 1'b1;
                    state_next = PRESSED;
                    cnt_next   = CNT_ONE;
                end
            end
            PRESSED, SECOND_PRESSED: begin
                if (btn_level) begin
                    if (cnt >= LONG_LAST) begin
                        long_next  = 1'b1;
                        state_next = LONG_HELD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
                    release_next = 1'b1;
                    if (state == PRESSED) begin
                        state_next = WAIT_SECOND;
                        cnt_next   = CNT_ONE;
                    end else begin
                        double_next = 1'b1;
                        state_next  = IDLE;
                        cnt_next    = '0;
                    end
                end
            end
            WAIT_SECOND: begin
                if (btn_level) begin
                    press_next = 1'b1;
                    state_next = SECOND_PRESSED;
                    cnt_next   = CNT_ONE;
                end else if (cnt >= GAP_LAST) begin
                    click_next = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            LONG_HELD: begin
                if (!btn_level) begin
                    release_next = 1'b1;
                    state_next   = IDLE;
                    cnt_next     = '0;
                end else begin
`ifdef BTN_DECODER_REPEAT_EN
                    // Counter restarts at the long-press edge, so each period is measured from it.
                    if (cnt >= CNT_W'(REPEAT_CLK_CNT - 1)) begin
                        repeat_next = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
`else
                    cnt_next = '0;
`endif
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        held_next = (state_next == PRESSED) || (state_next == SECOND_PRESSED) ||
                    (state_next == LONG_HELD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            press_pulse        <= 1'b0;
            release_pulse      <= 1'b0;
            click_pulse        <= 1'b0;
            double_click_pulse <= 1'b0;
            long_press_pulse   <= 1'b0;
            held               <= 1'b0;
        end else begin
            state              <= state_next;
            cnt                <= cnt_next;
            press_pulse        <= press_next;
            release_pulse      <= release_next;
            click_pulse        <= click_next;
            double_click_pulse <= double_next;
            long_press_pulse   <= long_next;
            held               <= held_next;
        end
    end

`ifdef BTN_DECODER_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_next;
        end
    end
`else
    assign repeat_pulse = 1'b0;
    logic unused_repeat;
    assign unused_repeat = repeat_next;
`endif

endmodule
